// File: rtl/data_mem_pkg.sv
// Shared constants and types for the synchronous MEM-stage data memory.
package data_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/data_mem_sync_if.sv
// Request/acknowledge bus between the MEM stage (master) and the data memory (slave).
interface data_mem_sync_if;

   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        ld_unsigned;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        ack;
   logic        busy;
   logic        err;

   modport master (
      output req, we, size, ld_unsigned, addr, wr_data,
      input  rd_data, ack, busy, err
   );

   modport slave (
      input  req, we, size, ld_unsigned, addr, wr_data,
      output rd_data, ack, busy, err
   );

endinterface

// File: rtl/data_mem_lane_align.sv
// Combinational lane steering: store byte enables, load extension, alignment check.
module data_mem_lane_align
   import data_mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        ld_unsigned,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wr_data,
   input  logic [31:0] rd_raw,
   output logic [3:0]  byte_en,
   output logic [31:0] wr_lanes,
   output logic [31:0] rd_ext,
   output logic        misalign
);

   // Lanes are relative to the access address: value byte k lands at addr+k.
   always_comb begin
      byte_en  = 4'b1111;
      rd_ext   = rd_raw;
      misalign = 1'b0;
      case (size)
         SZ_BYTE: begin
            byte_en = 4'b0001;
            rd_ext  = {{24{~ld_unsigned & rd_raw[7]}}, rd_raw[7:0]};
         end
         SZ_HALF: begin
            byte_en  = 4'b0011;
            rd_ext   = {{16{~ld_unsigned & rd_raw[15]}}, rd_raw[15:0]};
            misalign = addr_lo[0];
         end
         default: misalign = (addr_lo != 2'b00);
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_wr_lane
         assign wr_lanes[8*gi +: 8] = byte_en[gi] ? wr_data[8*gi +: 8] : 8'h00;
      end
   endgenerate

endmodule

// File: rtl/data_mem_sync.sv
// Clocked byte-addressable data memory with wait states and req/ack handshake.
// Optional rejection of bad accesses is enabled by defining DATA_MEM_ERR_CHECK_EN.
module data_mem_sync
   import data_mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   data_mem_sync_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d, ldu_q, ldu_d, err_q, err_d;
   logic [1:0]        size_q, size_d;
   logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, rd_data_q, rd_data_d;

   logic                  enter_resp, reject, commit, misalign;
   logic [ADDR_WIDTH-1:0] eff_addr;
   logic [ADDR_WIDTH-1:0] lane_addr [4];
   logic [31:0]           rd_raw, rd_ext, wr_lanes;
   logic [3:0]            byte_en;

   logic [7:0] mem_q [DEPTH] = '{default: 8'h00};

   // The *_d copies of the request fields are the access being resolved, valid
   // both on the accept edge (zero wait states) and on the last WAIT edge.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      size_d     = size_q;
      ldu_d      = ldu_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req) begin
               we_d    = bus.we;
               size_d  = bus.size;
               ldu_d   = bus.ld_unsigned;
               addr_d  = bus.addr;
               wdata_d = bus.wr_data;
               if (WAIT_STATES == 0) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(WAIT_STATES - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      eff_addr = addr_d[ADDR_WIDTH-1:0];
      if (size_d == SZ_HALF) begin
         eff_addr[0] = 1'b0;
      end else if (size_d != SZ_BYTE) begin
         eff_addr[1:0] = 2'b00;
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_addr[gi]       = eff_addr + ADDR_WIDTH'(gi);
         assign rd_raw[8*gi +: 8]   = mem_q[lane_addr[gi]];
      end
   endgenerate

   data_mem_lane_align u_align (
      .size        (size_d),
      .ld_unsigned (ldu_d),
      .addr_lo     (addr_d[1:0]),
      .wr_data     (wdata_d),
      .rd_raw      (rd_raw),
      .byte_en     (byte_en),
      .wr_lanes    (wr_lanes),
      .rd_ext      (rd_ext),
      .misalign    (misalign)
   );

`ifdef DATA_MEM_ERR_CHECK_EN
   assign reject = misalign | ((addr_d >> ADDR_WIDTH) != 32'd0) | (size_d == SZ_ILL);
`else
   logic unused_bits;
   assign reject      = 1'b0;
   assign unused_bits = ^{misalign, addr_d[31:ADDR_WIDTH]};
`endif

   assign commit = enter_resp & ~reject & we_d;

   always_comb begin
      rd_data_d = rd_data_q;
      err_d     = (state_q == RESP) ? 1'b0 : err_q;
      if (enter_resp) begin
         err_d = reject;
         if (!reject && !we_d) begin
            rd_data_d = rd_ext;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         size_q    <= SZ_BYTE;
         ldu_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         size_q    <= size_d;
         ldu_q     <= ldu_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rd_data_q <= rd_data_d;
         err_q     <= err_d;
      end
   end

   // Contents survive reset; a reset on the RESP-entry edge suppresses the write.
   always_ff @(posedge clk) begin
      if (rst_n && commit) begin
         for (int k = 0; k < 4; k++) begin
            if (byte_en[k]) begin
               mem_q[lane_addr[k]] <= wr_lanes[8*k +: 8];
            end
         end
      end
   end

   assign bus.rd_data = rd_data_q;
   assign bus.ack     = (state_q == RESP);
   assign bus.err     = err_q;
   assign bus.busy    = (state_q != IDLE) | bus.req;

endmodule

// File: doc/data_mem_sync.md
# data_mem_sync

Synchronous, parametrised data memory for the MEM stage of the pipelined MIPS core. It replaces the combinational byte/word memory with a clocked request/acknowledge interface and configurable wait states. It supports byte, halfword and word access with little-endian lane steering and signed or unsigned load extension. The `busy` output stalls the pipeline while an access is outstanding.

## Interface
- `ADDR_WIDTH`, default 10: byte-address width; memory holds 2^ADDR_WIDTH bytes.
- `WAIT_STATES`, default 0: extra cycles per access, legal range 0..7.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `req` in 1: access request, sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `ld_unsigned` in 1: 1 = zero-extend loads, 0 = sign-extend loads.
- `addr` in 32: byte address.
- `wr_data` in 32: store data, taken from the low bytes.
- `rd_data` out 32: load result, registered.
- `ack` out 1: one-cycle completion pulse.
- `busy` out 1: high from the accept cycle through the ack cycle.
- `err` out 1: with `ack`, marks an access that was rejected.

## Operation
- FSM states:
  - IDLE: if `req`=1, latch `we`, `size`, `ld_unsigned`, `addr`, `wr_data`. If WAIT_STATES=0 go to RESP; otherwise go to WAIT with `cnt` = WAIT_STATES-1.
  - WAIT: if `cnt`=0 go to RESP, else decrement `cnt`.
  - RESP: `ack`=1, then return to IDLE unconditionally.
- On the edge entering RESP:
  - A store commits its byte lanes.
  - A load updates `rd_data`.
  - `err` is registered.
- Lane mapping, little-endian: byte k of the value goes to location addr+k.
  - Halfword: bytes 0..1.
  - Word: bytes 0..3.
- Loads:
  - Byte and halfword results are sign- or zero-extended to 32 bits per the latched `ld_unsigned`.
  - Word loads ignore `ld_unsigned`.
- Stores do not change `rd_data`. A rejected access leaves memory and `rd_data` unchanged.
- `busy` = (state != IDLE) | (state == IDLE & `req`), so the stall takes effect in the request cycle itself.
- A `req` seen outside IDLE is ignored. The pipeline holds it via `busy`.
- Memory contents are initialised to zero at elaboration and are not affected by reset.

## Timing
- Values on reset: `rd_data`=0, `ack`=0, `err`=0, state=IDLE, `cnt`=0. `busy` follows `req` combinationally.
- Latency: `ack` is high in the cycle after WAIT_STATES+1 rising edges following the accept edge.
- Throughput: one access per WAIT_STATES+2 cycles. The earliest next accept is in the cycle after `ack`.
- Reset mid-access, in WAIT or on the RESP-entry edge: the access is aborted, no store is committed and no `ack` is produced.
- Address arithmetic uses only `addr[ADDR_WIDTH-1:0]`, never wider.

## Configuration
- Macro: `DATA_MEM_ERR_CHECK_EN`.
- When defined, any of these returns `ack` with `err`=1 and no side effect:
  - Misaligned access (halfword with `addr[0]`=1, word with `addr[1:0]`!=0).
  - `addr` >= 2^ADDR_WIDTH.
  - `size`=11.
- When undefined:
  - `err` is tied to 0.
  - Low address bits are forced to alignment (halfword clears bit 0, word clears bits 1:0).
  - High address bits are ignored, so the address wraps.
  - `size`=11 is treated as a word access.

## Structure
- `data_mem_pkg`:
  - Size constants `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - State enum `IDLE`/`WAIT`/`RESP`.
  - Width of `cnt`, 3 bits.
- Sub-module `data_mem_lane_align`, combinational:
  - Store byte-enable and lane steering.
  - Load byte extraction and extension.
  - Alignment-error detection.

## Test plan
- WAIT_STATES=0: store word 0x11223344 at 0x8, then load word at 0x8 → `ack` one cycle after each accept; `rd_data`=0x11223344; load byte at 0x9 with `ld_unsigned`=0 → 0x00000033.
- Store byte 0xF0 at 0x10, then load byte signed → 0xFFFFFFF0; load byte unsigned → 0x000000F0; load halfword signed at 0x10 → 0x000000F0.
- WAIT_STATES=3: a single load gives `busy` high for 5 cycles and `ack` exactly 4 edges after accept; a `req` held across the wait is accepted exactly once.
- With `DATA_MEM_ERR_CHECK_EN`:
  - Word store at 0x6 → `err`=1, memory unchanged.
  - Address 0x400 with ADDR_WIDTH=10 → `err`=1.
- Without `DATA_MEM_ERR_CHECK_EN`: word load at 0x406 reads the word at 0x004.
- `rst_n` low in WAIT during a store to 0x20 → no `ack`; a later load at 0x20 returns the old value; all outputs read 0 after reset.
